ita_output_fifo: RTL

ITA_OUTPUT_FIFO -- requirements
Module: ita_output_fifo

---
 rtl/ita_output_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ita_output_fifo.sv
// Output FIFO between the ITA datapath and the controller: buffers requantized beats with tile tags.
// Define ITA_OUTPUT_FIFO_BYPASS_EN to let beats pass straight through while the FIFO is empty.
module ita_output_fifo #(
    parameter int unsigned DEPTH = 4,
    // ita_package N*WO (16 x 8-bit lanes)
    parameter int unsigned DW    = 128,
    parameter int unsigned CW    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [DW-1:0]                data_i,
    input  logic [CW-1:0]                tile_x_i,
    input  logic [CW-1:0]                tile_y_i,
    input  logic                         last_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [DW-1:0]                data_o,
    output logic [CW-1:0]                tile_x_o,
    output logic [CW-1:0]                tile_y_o,
    output logic                         last_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         tile_done_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned EW   = DW + 2 * CW + 1;

    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StPartial = 2'd1;
    localparam logic [1:0] StFull    = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            tile_done_q, tile_done_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic [EW-1:0]   in_entry;
    logic [EW-1:0]   head;
    logic            bypass_active;
    logic            push, pop, wr_en, rd_en;

    assign in_entry = {data_i, tile_x_i, tile_y_i, last_i};
    assign empty_o  = (state_q == StEmpty);
    assign full_o   = (state_q == StFull);
    assign ready_o  = !full_o;

`ifdef ITA_OUTPUT_FIFO_BYPASS_EN
    assign bypass_active = empty_o;
    assign valid_o       = empty_o ? valid_i : 1'b1;
    assign head          = empty_o ? in_entry : mem_q[rd_ptr_q];
`else
    assign bypass_active = 1'b0;
    assign valid_o       = !empty_o;
    assign head          = mem_q[rd_ptr_q];
`endif

    assign {data_o, tile_x_o, tile_y_o, last_o} = head;

    assign push  = valid_i && ready_o;
    assign pop   = valid_o && ready_i;
    // A beat consumed straight from the input never touches storage
    assign wr_en = push && !(bypass_active && pop);
    assign rd_en = pop && !bypass_active;

    assign count_o     = count_q;
    assign tile_done_o = tile_done_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tile_done_d = 1'b0;
        if (flush_i) begin
            state_d  = StEmpty;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            tile_done_d = pop && last_o;
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            case (state_q)
                StEmpty: begin
                    if (wr_en) begin
                        state_d = StPartial;
                        count_d = count_q + CNTW'(1);
                    end
                end
                StPartial: begin
                    if (wr_en && !rd_en) begin
                        count_d = count_q + CNTW'(1);
                        if (count_q == CNTW'(DEPTH - 1)) state_d = StFull;
                    end else if (rd_en && !wr_en) begin
                        count_d = count_q - CNTW'(1);
                        if (count_q == CNTW'(1)) state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (rd_en) begin
                        state_d = StPartial;
                        count_d = count_q - CNTW'(1);
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tile_done_q <= tile_done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

endmodule
